multicycle_control_unit: RTL
============================

# multicycle_control_unit

Parametrised multi-cycle successor to the single-cycle opcode decoder. It sequences every instruction through FETCH/DECODE/EXEC/MEM/WB states and owns the program counter. It takes the target address from the instruction's immediate field, adds a conditional branch and a halt, and waits on a data-memory handshake with timeout. It sits between the instruction source, the ALU, the register file and data memory.

## Interface
- OPCODE_W, 4: opcode width; opcode = instr_i[INSTR_W-1 -: OPCODE_W]
- ALUOP_W, 8: ALU operation code width
- ADDR_W, 8: PC/address width; immediate = instr_i[ADDR_W-1:0]
- INSTR_W, 16: instruction width; must satisfy INSTR_W >= OPCODE_W+ADDR_W
- MEM_TIMEOUT, 15: maximum MEM-state cycles before abort; 1..255
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- instr_i  input  INSTR_W  instruction word, sampled when instr_valid_i && instr_ready_o
- instr_valid_i  input  1  instruction source has a word
- instr_ready_o  output  1  high only in FETCH
- zero_i  input  1  ALU zero flag, sampled in EXEC of BEQ
- mem_ready_i  input  1  data memory completes current request
- alu_op_o  output  ALUOP_W  ALU operation, opcode zero-extended
- mem_read_o, mem_write_o  output  1  data-memory request, held through MEM
- reg_write_o  output  1  register-file write strobe, one cycle in WB
- branch_o, jump_o  output  1  one-cycle strobes
- address_o  output  ADDR_W  data address (immediate) in MEM; 0 otherwise
- pc_o  output  ADDR_W  program counter
- illegal_o  output  1  one-cycle pulse on undefined opcode
- timeout_o  output  1  one-cycle pulse on memory timeout
- halted_o  output  1  high in HALT

## Operation
- Opcodes: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 LD, 5 ST, 6 JMP, 7 BEQ, 8 HALT. All other values are illegal.
- Outputs decode from the state register and the latched instruction register only. No output depends combinationally on an input.
- FETCH: instr_ready_o=1. On handshake, latch instr_i and go to DECODE. Otherwise stay in FETCH.
- DECODE, by opcode:
  - Illegal: illegal_o=1, pc+=1, go to FETCH.
  - HALT: go to HALT.
  - JMP: jump_o=1, pc<=imm, go to FETCH.
  - All others: go to EXEC.
- EXEC, by opcode:
  - 0-3: alu_op_o=opcode, go to WB.
  - LD, ST: go to MEM; clear the timeout counter.
  - BEQ: alu_op_o=3 (SUB), branch_o=1. If zero_i, pc<=imm; else pc+=1. Go to FETCH.
- MEM:
  - mem_read_o (LD) or mem_write_o (ST) held high; address_o=imm; counter increments each cycle.
  - When mem_ready_i: LD goes to WB; ST does pc+=1 and goes to FETCH.
  - Timeout: if the counter reaches MEM_TIMEOUT-1 without mem_ready_i, timeout_o=1, pc+=1, go to FETCH, no write-back.
  - mem_ready_i wins if it coincides with the last allowed cycle.
- WB: reg_write_o=1, alu_op_o holds the EXEC value (0 for LD), pc+=1, go to FETCH.
- HALT: all strobes 0; halted_o=1; ignores instr_valid_i. Exits only via reset.
- PC arithmetic is modulo 2^ADDR_W: max+1 wraps to 0.
- mem_ready_i outside MEM and zero_i outside BEQ EXEC are ignored.

## Timing
- Reset: while rst_n=0 at a clock edge, the next state is FETCH and pc_o, the instruction register and the counter are cleared. All outputs are 0 except instr_ready_o, which is 1 in the first cycle after rst_n rises.
- Reset mid-instruction (including in MEM with a request pending) aborts the instruction. The request is dropped with no write-back.
- Minimum cycles per instruction, assuming instr_valid_i is already high in FETCH:
  - ALU op: 4
  - LD: 5, plus memory wait
  - ST: 4, plus memory wait
  - BEQ: 3
  - JMP: 2
  - Illegal: 2
- The PC update is visible on pc_o the cycle after the state that performs it.
- Strobes are exactly one cycle. mem_read_o/mem_write_o stay high from MEM entry through the cycle mem_ready_i is sampled high, inclusive.

## Test plan
- Reset, then ADD (0x2000) with valid always high → reg_write_o=1 with alu_op_o=0x02 in cycle 4; pc_o 0→1.
- LD imm 0x3C, mem_ready_i after 3 MEM cycles → mem_read_o high 3 cycles with address_o=0x3C, then one reg_write_o cycle, pc_o=1.
- ST with mem_ready_i never asserted, MEM_TIMEOUT=15 → mem_write_o high 15 cycles, then timeout_o pulse; no reg_write_o; next state FETCH.
- BEQ imm 0x80: zero_i=1 → pc_o=0x80. Repeat with zero_i=0 → pc_o=prev+1. Then JMP 0xFF, then an ALU op → pc_o wraps from 0xFF to 0x00.
- Opcode 0xA → single illegal_o pulse, pc+1. Then HALT (0x8) → halted_o=1 and instr_ready_o=0 indefinitely; rst_n low clears both.
- rst_n asserted in the middle of a MEM wait → next cycle: all strobes 0, pc_o=0; instr_ready_o=1 in the first cycle after rst_n rises.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, owns the PC,
// and waits on a data-memory handshake with a bounded timeout.
module multicycle_control_unit #(
  parameter int unsigned OPCODE_W    = 4,
  parameter int unsigned ALUOP_W     = 8,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned INSTR_W     = 16,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               instr_valid_i,
  output logic               instr_ready_o,
  input  logic               zero_i,
  input  logic               mem_ready_i,
  output logic [ALUOP_W-1:0] alu_op_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               reg_write_o,
  output logic               branch_o,
  output logic               jump_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               illegal_o,
  output logic               timeout_o,
  output logic               halted_o
);

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

  localparam logic [OPCODE_W-1:0] OpSub  = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OpLd   = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OpSt   = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OpJmp  = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OpBeq  = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OpHalt = OPCODE_W'(8);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [ADDR_W-1:0]   imm_q, imm_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                timeout_q, timeout_d;
  logic                is_illegal;

  // Bits between the immediate and the opcode carry no meaning.
  if (INSTR_W > OPCODE_W + ADDR_W) begin : g_unused
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr_i[INSTR_W-OPCODE_W-1:ADDR_W];
  end

  assign is_illegal = (op_q > OpHalt);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    op_d      = op_q;
    imm_d     = imm_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (instr_valid_i) begin
          op_d    = instr_i[INSTR_W-1 -: OPCODE_W];
          imm_d   = instr_i[ADDR_W-1:0];
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (is_illegal) begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = StFetch;
        end else if (op_q == OpHalt) begin
          state_d = StHalt;
        end else if (op_q == OpJmp) begin
          pc_d    = imm_q;
          state_d = StFetch;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (op_q == OpLd || op_q == OpSt) begin
          cnt_d   = 8'd0;
          state_d = StMem;
        end else if (op_q == OpBeq) begin
          pc_d    = zero_i ? imm_q : pc_q + ADDR_W'(1);
          state_d = StFetch;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        cnt_d = cnt_q + 8'd1;
        // A completion on the last allowed cycle takes priority over the timeout.
        if (mem_ready_i) begin
          if (op_q == OpLd) begin
            state_d = StWb;
          end else begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = StFetch;
          end
        end else if (cnt_q == 8'(MEM_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          pc_d      = pc_q + ADDR_W'(1);
          state_d   = StFetch;
        end
      end
      StWb: begin
        pc_d    = pc_q + ADDR_W'(1);
        state_d = StFetch;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      pc_q      <= '0;
      op_q      <= '0;
      imm_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      op_q      <= op_d;
      imm_q     <= imm_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    instr_ready_o = 1'b0;
    alu_op_o      = '0;
    mem_read_o    = 1'b0;
    mem_write_o   = 1'b0;
    reg_write_o   = 1'b0;
    branch_o      = 1'b0;
    jump_o        = 1'b0;
    address_o     = '0;
    illegal_o     = 1'b0;
    halted_o      = 1'b0;
    unique case (state_q)
      StFetch: instr_ready_o = 1'b1;
      StDecode: begin
        illegal_o = is_illegal;
        jump_o    = (op_q == OpJmp);
      end
      StExec: begin
        if (op_q <= OpSub) begin
          alu_op_o = ALUOP_W'(op_q);
        end else if (op_q == OpBeq) begin
          alu_op_o = ALUOP_W'(OpSub);
          branch_o = 1'b1;
        end
      end
      StMem: begin
        mem_read_o  = (op_q == OpLd);
        mem_write_o = (op_q == OpSt);
        address_o   = imm_q;
      end
      StWb: begin
        reg_write_o = 1'b1;
        alu_op_o    = (op_q == OpLd) ? '0 : ALUOP_W'(op_q);
      end
      StHalt:  halted_o = 1'b1;
      default: ;
    endcase
  end

  assign timeout_o = timeout_q;
  assign pc_o      = pc_q;

endmodule
